// File: rtl/csr_unit_m.sv
// Machine-mode CSR file for a single-hart RV32 core.
// Covers Zicsr accesses, trap/MRET state, 64-bit counters and the external interrupt gate.
module csr_unit_m #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned NUM_HPM     = 2,
    parameter logic [31:0] MTVEC_RESET = 32'h0,
    parameter logic [31:0] HART_ID     = 32'h0,
    localparam int unsigned HPM_W      = (NUM_HPM > 0) ? NUM_HPM : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             csr_en,
    input  logic [1:0]       csr_op,
    input  logic [11:0]      csr_addr,
    input  logic [XLEN-1:0]  csr_wdata,
    output logic [XLEN-1:0]  csr_rdata,
    output logic             csr_illegal,
    input  logic             instr_ret,
    input  logic [HPM_W-1:0] hpm_event,
    input  logic             irq_ext,
    output logic             irq_take,
    input  logic             trap_valid,
    input  logic [XLEN-1:0]  trap_cause,
    input  logic [XLEN-1:0]  trap_pc,
    input  logic [XLEN-1:0]  trap_tval,
    input  logic             mret,
    output logic [XLEN-1:0]  trap_vector,
    output logic [XLEN-1:0]  epc_out
);

    localparam int unsigned NCNT      = NUM_HPM + 2;
    localparam logic [31:0] MISA_VAL  = 32'h4000_1120;
    localparam logic [31:0] INH_MASK  = 32'h5 | 32'(((64'd1 << NUM_HPM) - 64'd1) << 3);

    // Low-half address of counter k: mcycle, minstret, then mhpmcounter3 onwards.
    function automatic logic [11:0] cnt_addr(int k);
        if (k == 0) return 12'hB00;
        if (k == 1) return 12'hB02;
        return 12'(32'hB01 + 32'(k));
    endfunction

    logic             mst_mie_q, mst_mie_d, mst_mpie_q, mst_mpie_d;
    logic             meie_q, meie_d;
    logic [XLEN-1:0]  mtvec_q, mtvec_d, mscratch_q, mscratch_d;
    logic [XLEN-1:0]  mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;
    logic [XLEN-1:0]  minhibit_q, minhibit_d;
    logic [63:0]      cnt_q [NCNT];
    logic [63:0]      cnt_d [NCNT];

    logic [XLEN-1:0]  old_val, new_val, tv_base;
    logic             implemented, wr_attempt, wr_en;
    logic [NCNT-1:0]  cnt_inc, cnt_inh;

    always_comb begin
        old_val     = '0;
        implemented = 1'b1;
        case (csr_addr)
            12'hF11, 12'hF12, 12'hF13: old_val = '0;
            12'hF14: old_val = HART_ID;
            12'h300: old_val = {19'b0, 2'b11, 3'b0, mst_mpie_q, 3'b0, mst_mie_q, 3'b0};
            12'h301: old_val = MISA_VAL;
            12'h304: old_val = {20'b0, meie_q, 11'b0};
            12'h305: old_val = mtvec_q;
            12'h320: old_val = minhibit_q;
            12'h340: old_val = mscratch_q;
            12'h341: old_val = mepc_q;
            12'h342: old_val = mcause_q;
            12'h343: old_val = mtval_q;
            12'h344: old_val = {20'b0, irq_ext, 11'b0};
            default: implemented = 1'b0;
        endcase
        for (int k = 0; k < NCNT; k++) begin
            if (csr_addr == cnt_addr(k)) begin
                old_val     = cnt_q[k][31:0];
                implemented = 1'b1;
            end
            if (csr_addr == (cnt_addr(k) | 12'h080)) begin
                old_val     = cnt_q[k][63:32];
                implemented = 1'b1;
            end
        end
    end

    always_comb begin
        case (csr_op)
            2'b01:   new_val = csr_wdata;
            2'b10:   new_val = old_val | csr_wdata;
            2'b11:   new_val = old_val & ~csr_wdata;
            default: new_val = old_val;
        endcase
    end

    // RS/RC with a zero operand is a pure read, so it never trips the read-only check.
    assign wr_attempt  = (csr_op == 2'b01) | (csr_op[1] & (csr_wdata != '0));
    assign csr_illegal = csr_en & (~implemented | ((csr_addr[11:10] == 2'b11) & wr_attempt));
    assign wr_en       = csr_en & wr_attempt & ~csr_illegal;
    assign csr_rdata   = old_val;

    always_comb begin
        cnt_inc    = '0;
        cnt_inh    = '0;
        cnt_inc[0] = 1'b1;
        cnt_inc[1] = instr_ret;
        cnt_inh[0] = minhibit_q[0];
        cnt_inh[1] = minhibit_q[2];
        for (int i = 0; i < NUM_HPM; i++) begin
            cnt_inc[i+2] = hpm_event[i];
            cnt_inh[i+2] = minhibit_q[i+3];
        end
    end

    always_comb begin
        mst_mie_d  = mst_mie_q;
        mst_mpie_d = mst_mpie_q;
        meie_d     = meie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;
        minhibit_d = minhibit_q;
        for (int k = 0; k < NCNT; k++) cnt_d[k] = cnt_q[k];

        if (wr_en) begin
            case (csr_addr)
                12'h304: meie_d     = new_val[11];
                12'h305: mtvec_d    = {new_val[31:2], new_val[1] ? 2'b00 : new_val[1:0]};
                12'h320: minhibit_d = new_val & INH_MASK;
                12'h340: mscratch_d = new_val;
                default: ;
            endcase
        end

        if (trap_valid) begin
            mepc_d     = {trap_pc[31:2], 2'b00};
            mcause_d   = trap_cause;
            mtval_d    = trap_tval;
            mst_mpie_d = mst_mie_q;
            mst_mie_d  = 1'b0;
        end else if (mret) begin
            mst_mie_d  = mst_mpie_q;
            mst_mpie_d = 1'b1;
        end else if (wr_en) begin
            case (csr_addr)
                12'h300: begin
                    mst_mie_d  = new_val[3];
                    mst_mpie_d = new_val[7];
                end
                12'h341: mepc_d   = {new_val[31:2], 2'b00};
                12'h342: mcause_d = new_val;
                12'h343: mtval_d  = new_val;
                default: ;
            endcase
        end

        // A software write to either half suppresses that cycle's increment.
        for (int k = 0; k < NCNT; k++) begin
            if (wr_en && csr_addr == cnt_addr(k)) begin
                cnt_d[k][31:0] = new_val;
            end else if (wr_en && csr_addr == (cnt_addr(k) | 12'h080)) begin
                cnt_d[k][63:32] = new_val;
            end else if (cnt_inc[k] && !cnt_inh[k]) begin
                cnt_d[k] = cnt_q[k] + 64'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mst_mie_q  <= 1'b0;
            mst_mpie_q <= 1'b0;
            meie_q     <= 1'b0;
            mtvec_q    <= MTVEC_RESET;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
            minhibit_q <= '0;
            for (int k = 0; k < NCNT; k++) cnt_q[k] <= '0;
        end else begin
            mst_mie_q  <= mst_mie_d;
            mst_mpie_q <= mst_mpie_d;
            meie_q     <= meie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
            minhibit_q <= minhibit_d;
            for (int k = 0; k < NCNT; k++) cnt_q[k] <= cnt_d[k];
        end
    end

    assign tv_base     = {mtvec_q[31:2], 2'b00};
    assign trap_vector = (mtvec_q[1:0] == 2'b01 && mcause_q[31])
                         ? tv_base + {mcause_q[29:0], 2'b00} : tv_base;
    assign epc_out     = mepc_q;
    assign irq_take    = mst_mie_q & meie_q & irq_ext;

endmodule

// File: tb/tb_csr_unit_m.sv
// Table-driven bench for csr_unit_m: each vector drives one cycle and its expectation
// travels through a scoreboard queue to the mid-cycle sample point.
module tb_csr_unit_m;

    localparam logic [1:0] RD = 2'b00, RW = 2'b01, RS = 2'b10, RC = 2'b11;
    localparam logic [4:0] E0 = 5'b00000, ERET = 5'b00001, EHPM = 5'b00010,
                           EIRQ = 5'b00100, EMRET = 5'b01000, ETRAP = 5'b10000;
    localparam int KNONE = 0, KRD = 1, KTV = 2, KEPC = 3, KIRQ = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        csr_en;
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata, csr_rdata;
    logic        csr_illegal, instr_ret, irq_ext, irq_take, trap_valid, mret;
    logic [1:0]  hpm_event;
    logic [31:0] trap_cause, trap_pc, trap_tval, trap_vector, epc_out;

    always #5 clk = ~clk;

    csr_unit_m #(
        .XLEN(32), .NUM_HPM(2), .MTVEC_RESET(32'h100), .HART_ID(32'h5)
    ) dut (
        .clk(clk), .rst(rst), .csr_en(csr_en), .csr_op(csr_op), .csr_addr(csr_addr),
        .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
        .instr_ret(instr_ret), .hpm_event(hpm_event), .irq_ext(irq_ext), .irq_take(irq_take),
        .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_pc(trap_pc),
        .trap_tval(trap_tval), .mret(mret), .trap_vector(trap_vector), .epc_out(epc_out)
    );

    typedef struct {
        string       name;
        logic [4:0]  ev;
        logic        en;
        logic [1:0]  op;
        logic [11:0] addr;
        logic [31:0] wd;
        int          kind;
        logic [31:0] exp_val;
        logic        exp_ill;
    } vec_t;

    typedef struct {
        string       name;
        int          kind;
        logic [31:0] exp_val;
        logic        exp_ill;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic add(input string name, input logic [4:0] ev, input logic en,
                       input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd,
                       input int kind, input logic [31:0] exp_val, input logic exp_ill);
        vecs.push_back('{name, ev, en, op, addr, wd, kind, exp_val, exp_ill});
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp_v);
        end
    endtask

    task automatic drive(input vec_t v);
        csr_en     = v.en;
        csr_op     = v.op;
        csr_addr   = v.addr;
        csr_wdata  = v.wd;
        instr_ret  = v.ev[0];
        hpm_event  = {1'b0, v.ev[1]};
        irq_ext    = v.ev[2];
        mret       = v.ev[3];
        trap_valid = v.ev[4];
        sb.push_back('{v.name, v.kind, v.exp_val, v.exp_ill});
    endtask

    task automatic sample();
        exp_t e;
        e = sb.pop_front();
        check({e.name, ".illegal"}, {31'b0, csr_illegal}, {31'b0, e.exp_ill});
        case (e.kind)
            KRD:  check({e.name, ".rdata"}, csr_rdata, e.exp_val);
            KTV:  check({e.name, ".trap_vector"}, trap_vector, e.exp_val);
            KEPC: check({e.name, ".epc_out"}, epc_out, e.exp_val);
            KIRQ: check({e.name, ".irq_take"}, {31'b0, irq_take}, e.exp_val);
            default: ;
        endcase
    endtask

    // Entered at #1 after a rising edge; leaves at the same point one cycle later.
    task automatic run_all();
        while (vecs.size() > 0) begin
            drive(vecs.pop_front());
            @(negedge clk);
            sample();
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b1;
        csr_en = 1'b0; csr_op = RD; csr_addr = '0; csr_wdata = '0;
        instr_ret = 1'b0; hpm_event = '0; irq_ext = 1'b0; trap_valid = 1'b0; mret = 1'b0;
        trap_pc = 32'h1003; trap_cause = 32'h8000_000B; trap_tval = 32'h55;

        add("rst_mcycle0",  E0, 1, RD, 12'hB00, 0, KRD, 32'h0, 0);
        add("rst_mcycle1",  E0, 1, RD, 12'hB00, 0, KRD, 32'h1, 0);
        add("rst_mstatus",  E0, 1, RD, 12'h300, 0, KRD, 32'h1800, 0);
        add("rst_mtvec",    E0, 1, RD, 12'h305, 0, KRD, 32'h100, 0);
        add("rst_mcycleh",  E0, 1, RD, 12'hB80, 0, KRD, 32'h0, 0);
        add("scr_rw",       E0, 1, RW, 12'h340, 32'hA5A5_0000, KRD, 32'h0, 0);
        add("scr_rs",       E0, 1, RS, 12'h340, 32'h0000_00FF, KRD, 32'hA5A5_0000, 0);
        add("scr_rc",       E0, 1, RC, 12'h340, 32'hA500_0000, KRD, 32'hA5A5_00FF, 0);
        add("scr_rd",       E0, 1, RD, 12'h340, 0, KRD, 32'h00A5_00FF, 0);
        add("hartid_rw",    E0, 1, RW, 12'hF14, 32'h1, KNONE, 0, 1);
        add("hartid_rs0",   E0, 1, RS, 12'hF14, 32'h0, KRD, 32'h5, 0);
        add("hartid_rd",    E0, 1, RD, 12'hF14, 0, KRD, 32'h5, 0);
        add("unimpl_rd",    E0, 1, RD, 12'h7C0, 0, KNONE, 0, 1);
        add("unimpl_noen",  E0, 0, RW, 12'h7C0, 32'h1, KNONE, 0, 0);
        add("vendor_rc",    E0, 1, RC, 12'hF11, 32'h4, KNONE, 0, 1);
        add("misa_rd",      E0, 1, RD, 12'h301, 0, KRD, 32'h4000_1120, 0);
        add("mip_rd",       E0, 1, RD, 12'h344, 0, KRD, 32'h0, 0);
        add("mip_rw",       E0, 1, RW, 12'h344, 32'hFFFF_FFFF, KRD, 32'h0, 0);
        add("mip_irq",    EIRQ, 1, RD, 12'h344, 0, KRD, 32'h800, 0);
        add("mtvec_rw2",    E0, 1, RW, 12'h305, 32'h202, KRD, 32'h100, 0);
        add("mtvec_mode2",  E0, 1, RD, 12'h305, 0, KRD, 32'h200, 0);
        add("mepc_rw",      E0, 1, RW, 12'h341, 32'h1007, KRD, 32'h0, 0);
        add("mepc_align",   E0, 1, RD, 12'h341, 0, KRD, 32'h1004, 0);
        add("mie_rw",       E0, 1, RW, 12'h304, 32'hFFFF_FFFF, KRD, 32'h0, 0);
        add("mie_rd",       E0, 1, RD, 12'h304, 0, KRD, 32'h800, 0);
        add("inh_rw",       E0, 1, RW, 12'h320, 32'hFFFF_FFFF, KRD, 32'h0, 0);
        add("inh_mask",     E0, 1, RD, 12'h320, 0, KRD, 32'h1D, 0);
        add("inh_clr",      E0, 1, RW, 12'h320, 32'h0, KRD, 32'h1D, 0);
        add("wrap_wh",      E0, 1, RW, 12'hB80, 32'hFFFF_FFFF, KNONE, 0, 0);
        add("wrap_wl",      E0, 1, RW, 12'hB00, 32'hFFFF_FFFE, KNONE, 0, 0);
        add("wrap_blk",     E0, 1, RD, 12'hB00, 0, KRD, 32'hFFFF_FFFE, 0);
        add("wrap_max",     E0, 1, RD, 12'hB00, 0, KRD, 32'hFFFF_FFFF, 0);
        add("wrap_hi0",     E0, 1, RD, 12'hB80, 0, KRD, 32'h0, 0);
        add("wrap_lo1",     E0, 1, RD, 12'hB00, 0, KRD, 32'h1, 0);
        add("cy_inh",       E0, 1, RW, 12'h320, 32'h1, KNONE, 0, 0);
        add("cy_wr",        E0, 1, RW, 12'hB00, 32'h50, KNONE, 0, 0);
        add("cy_frz0",      E0, 1, RD, 12'hB00, 0, KRD, 32'h50, 0);
        add("cy_frz1",      E0, 1, RD, 12'hB00, 0, KRD, 32'h50, 0);
        add("cy_uninh",     E0, 1, RW, 12'h320, 32'h0, KRD, 32'h1, 0);
        add("cy_frz2",      E0, 1, RD, 12'hB00, 0, KRD, 32'h50, 0);
        add("cy_run",       E0, 1, RD, 12'hB00, 0, KRD, 32'h51, 0);
        add("ir_clr",       E0, 1, RW, 12'hB02, 32'h0, KNONE, 0, 0);
        add("ir_ret",     ERET, 1, RD, 12'hB02, 0, KRD, 32'h0, 0);
        add("ir_one",       E0, 1, RD, 12'hB02, 0, KRD, 32'h1, 0);
        add("ir_wrwin",   ERET, 1, RW, 12'hB02, 32'h20, KRD, 32'h1, 0);
        add("ir_rd",        E0, 1, RD, 12'hB02, 0, KRD, 32'h20, 0);
        add("hpm_ev",     EHPM, 1, RD, 12'hB03, 0, KRD, 32'h0, 0);
        add("hpm_one",      E0, 1, RD, 12'hB03, 0, KRD, 32'h1, 0);
        add("hpm_hi",       E0, 1, RD, 12'hB83, 0, KRD, 32'h0, 0);
        add("trap_tvec",    E0, 1, RW, 12'h305, 32'h201, KNONE, 0, 0);
        add("trap_mie",     E0, 1, RW, 12'h300, 32'h8, KRD, 32'h1800, 0);
        add("trap_mst0",    E0, 1, RD, 12'h300, 0, KRD, 32'h1808, 0);
        add("trap_take",  ETRAP, 0, RD, 12'h000, 0, KNONE, 0, 0);
        add("trap_mst1",    E0, 1, RD, 12'h300, 0, KRD, 32'h1880, 0);
        add("trap_vec",     E0, 0, RD, 12'h000, 0, KTV, 32'h22C, 0);
        add("trap_mepc",    E0, 1, RD, 12'h341, 0, KRD, 32'h1000, 0);
        add("trap_mcause",  E0, 1, RD, 12'h342, 0, KRD, 32'h8000_000B, 0);
        add("trap_mtval",   E0, 1, RD, 12'h343, 0, KRD, 32'h55, 0);
        add("mret_epc",  EMRET, 0, RD, 12'h000, 0, KEPC, 32'h1000, 0);
        add("mret_mst",     E0, 1, RD, 12'h300, 0, KRD, 32'h1888, 0);
        add("coll_trap",  ETRAP, 1, RW, 12'h300, 32'h8, KRD, 32'h1888, 0);
        add("coll_mst",     E0, 1, RD, 12'h300, 0, KRD, 32'h1880, 0);
        add("coll_mepc",    E0, 1, RD, 12'h341, 0, KRD, 32'h1000, 0);
        add("irq_mie",      E0, 1, RW, 12'h300, 32'h8, KRD, 32'h1880, 0);
        add("irq_on",     EIRQ, 0, RD, 12'h000, 0, KIRQ, 32'h1, 0);
        add("irq_off",      E0, 0, RD, 12'h000, 0, KIRQ, 32'h0, 0);
        add("mret_coll", EMRET, 1, RW, 12'h300, 32'h0, KRD, 32'h1808, 0);
        add("mret_win",     E0, 1, RD, 12'h300, 0, KRD, 32'h1880, 0);

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        run_all();

        // Reset must override a simultaneous CSR write and trap.
        rst = 1'b1;
        csr_en = 1'b1; csr_op = RW; csr_addr = 12'h340; csr_wdata = 32'h123;
        trap_valid = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        add("rstdom_scr",   E0, 1, RD, 12'h340, 0, KRD, 32'h0, 0);
        add("rstdom_mepc",  E0, 1, RD, 12'h341, 0, KRD, 32'h0, 0);
        add("rstdom_tvec",  E0, 1, RD, 12'h305, 0, KRD, 32'h100, 0);
        add("rstdom_mst",   E0, 1, RD, 12'h300, 0, KRD, 32'h1800, 0);
        run_all();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
